// File: rtl/pmod_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : pmod_arb_pkg                                               |
// | Shared types and constants for the PMOD port arbiter: FSM state     |
// | encoding, counter-width helper and the pin high-Z constant.          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package pmod_arb_pkg;

  // Arbiter FSM states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  // Bits needed to hold any value in 0..max_val (at least one bit)
  function automatic int cnt_w(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

  // Default timing knobs and the counter widths they imply
  localparam int MAX_HOLD_DEF   = 1024;
  localparam int GAP_CYCLES_DEF = 2;
  localparam int HOLD_CNT_W     = cnt_w(MAX_HOLD_DEF);
  localparam int GAP_CNT_W      = cnt_w(GAP_CYCLES_DEF);

  // Tri-state enable level that releases a pin (replicated to pin width)
  localparam logic c_TRI_HIZ = 1'b1;

endpackage : pmod_arb_pkg
`default_nettype wire

// File: rtl/rr_picker.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_picker                                                  |
// | Combinational round-robin pick: first asserted request at or after  |
// | ptr, wrapping. Returns one-hot, index and a valid flag.              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rr_picker
  import pmod_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         onehot,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       valid
);

  localparam int c_IDW = $clog2(NUM_REQ);

  logic [c_IDW-1:0] w_cand;

  // Scan NUM_REQ positions starting at ptr; the first hit wins
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    w_cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = c_IDW'((int'(ptr) + i) % NUM_REQ);
      if (!valid && req[w_cand]) begin
        valid          = 1'b1;
        onehot[w_cand] = 1'b1;
        idx            = w_cand;
      end
    end
  end

endmodule : rr_picker
`default_nettype wire

// File: rtl/pmod_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pmod_port_arbiter                                          |
// | Shares one PMOD connector between NUM_REQ requesters. Round-robin    |
// | ownership, forced high-Z turnaround gap between owners, optional     |
// | max-hold preemption and a 2-flop synchronized input path.            |
// | Optional macro: PMOD_ARB_LOCK_EN adds rq_lock, which freezes the     |
// | hold counter and suppresses preemption while the owner holds it.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pmod_port_arbiter
  import pmod_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int MAX_HOLD   = MAX_HOLD_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
`ifdef PMOD_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]           rq_lock,
`endif
  output logic [NUM_REQ-1:0]           grant,
  input  logic [NUM_REQ*WIDTH-1:0]     rq_data_out,
  input  logic [NUM_REQ*WIDTH-1:0]     rq_tri_out,
  output logic [NUM_REQ*WIDTH-1:0]     rq_data_in,
  output logic [WIDTH-1:0]             pmod_data_out,
  output logic [WIDTH-1:0]             pmod_tri_out,
  input  logic [WIDTH-1:0]             pmod_data_in,
  output logic [$clog2(NUM_REQ)-1:0]   owner_id,
  output logic                         busy
);

  localparam int c_IDW    = $clog2(NUM_REQ);
  localparam int c_HOLD_W = cnt_w(MAX_HOLD);
  localparam int c_GAP_W  = cnt_w(GAP_CYCLES);

  // Preemption fires on the edge where the waiting count reaches MAX_HOLD,
  // i.e. when the registered count already equals MAX_HOLD-1.
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST  = c_HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [c_GAP_W-1:0]  c_GAP_LAST   = c_GAP_W'(GAP_CYCLES - 1);
  localparam logic [c_IDW-1:0]    c_ID_LAST    = c_IDW'(NUM_REQ - 1);
  localparam logic                c_PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [WIDTH-1:0]    c_PINS_HIZ   = {WIDTH{c_TRI_HIZ}};

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [NUM_REQ-1:0]    r_grant;
  logic [NUM_REQ-1:0]    w_grant_nxt;
  logic [c_IDW-1:0]      r_owner;
  logic [c_IDW-1:0]      w_owner_nxt;
  logic [c_IDW-1:0]      r_ptr;
  logic [c_IDW-1:0]      w_ptr_nxt;
  logic [c_HOLD_W-1:0]   r_hold;
  logic [c_HOLD_W-1:0]   w_hold_nxt;
  logic [c_GAP_W-1:0]    r_gap;
  logic [c_GAP_W-1:0]    w_gap_nxt;
  logic [WIDTH-1:0]      r_pin_data;
  logic [WIDTH-1:0]      w_pin_data_nxt;
  logic [WIDTH-1:0]      r_pin_tri;
  logic [WIDTH-1:0]      w_pin_tri_nxt;
  logic [WIDTH-1:0]      r_sync1;
  logic [WIDTH-1:0]      r_sync2;

  logic [NUM_REQ-1:0]    w_pick_onehot;
  logic [c_IDW-1:0]      w_pick_idx;
  logic                  w_pick_valid;
  logic [WIDTH-1:0]      w_own_data;
  logic [WIDTH-1:0]      w_own_tri;
  logic                  w_others_wait;
  logic                  w_owner_req;
  logic                  w_lock;
  logic                  w_preempt;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (req),
    .ptr    (r_ptr),
    .onehot (w_pick_onehot),
    .idx    (w_pick_idx),
    .valid  (w_pick_valid)
  );

  // r_grant is one-hot (or zero), so it doubles as the owner mask
  assign w_others_wait = |(req & ~r_grant);
  assign w_owner_req   = |(req & r_grant);

`ifdef PMOD_ARB_LOCK_EN
  assign w_lock = |(rq_lock & r_grant);
`else
  assign w_lock = 1'b0;
`endif

  // Select the owner's drive and enable slices with a one-hot AND-OR mux
  always_comb begin
    w_own_data = '0;
    w_own_tri  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) begin
        w_own_data = w_own_data | rq_data_out[k*WIDTH +: WIDTH];
        w_own_tri  = w_own_tri  | rq_tri_out[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and registered-output decode; pins default to released
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_owner_nxt    = r_owner;
    w_ptr_nxt      = r_ptr;
    w_hold_nxt     = r_hold;
    w_gap_nxt      = r_gap;
    w_pin_data_nxt = '0;
    w_pin_tri_nxt  = c_PINS_HIZ;
    w_preempt      = 1'b0;

    case (r_state)
      IDLE: begin
        w_hold_nxt = '0;
        w_gap_nxt  = '0;
        if (w_pick_valid) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_pick_onehot;
          w_owner_nxt = w_pick_idx;
        end
      end

      GRANT: begin
        w_pin_data_nxt = w_own_data;
        w_pin_tri_nxt  = w_own_tri;

        // Count only cycles in which someone else is waiting; a lock freezes it
        if (!w_lock) begin
          if (w_others_wait) begin
            if (r_hold != c_HOLD_LAST) begin
              w_hold_nxt = r_hold + 1'b1;
            end
          end else begin
            w_hold_nxt = '0;
          end
        end

        w_preempt = c_PREEMPT_EN && !w_lock && w_others_wait && (r_hold == c_HOLD_LAST);

        if (!w_owner_req || w_preempt) begin
          w_state_nxt    = TURN;
          w_grant_nxt    = '0;
          w_pin_data_nxt = '0;
          w_pin_tri_nxt  = c_PINS_HIZ;
          w_ptr_nxt      = (r_owner == c_ID_LAST) ? '0 : r_owner + 1'b1;
          w_hold_nxt     = '0;
          w_gap_nxt      = '0;
        end
      end

      TURN: begin
        if (r_gap == c_GAP_LAST) begin
          w_state_nxt = IDLE;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State, arbitration bookkeeping and registered pin drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_hold     <= '0;
      r_gap      <= '0;
      r_pin_data <= '0;
      r_pin_tri  <= c_PINS_HIZ;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold     <= w_hold_nxt;
      r_gap      <= w_gap_nxt;
      r_pin_data <= w_pin_data_nxt;
      r_pin_tri  <= w_pin_tri_nxt;
    end
  end

  // Two-flop synchronizer on the pin readback
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pmod_data_in;
      r_sync2 <= r_sync1;
    end
  end

  // Only the current owner sees live pin data
  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_din
      assign rq_data_in[k*WIDTH +: WIDTH] = r_grant[k] ? r_sync2 : '0;
    end
  endgenerate

  assign grant         = r_grant;
  assign owner_id      = r_owner;
  assign busy          = (r_state != IDLE);
  assign pmod_data_out = r_pin_data;
  assign pmod_tri_out  = r_pin_tri;

endmodule : pmod_port_arbiter
`default_nettype wire
